// File: rtl/read_bank_filler_if.sv
// read_bank_filler_if: control, memory-beat stream and bank-write bus of the read bank filler.
interface read_bank_filler_if #(
  parameter int BANK_WIDTH             = 10,
  parameter int MEM_BUFFER_DEPTH_BYTES = 512
);
  localparam int WORDS = MEM_BUFFER_DEPTH_BYTES / 8;
  logic                                      start;
  logic [$clog2(WORDS):0]                    row_words;
  logic [$clog2(BANK_WIDTH):0]               num_rows;
  logic [63:0]                               mem_data;
  logic                                      mem_valid;
  logic                                      mem_ready;
  logic                                      wr;
  logic [$clog2(BANK_WIDTH)-1:0]             write_sel;
  logic [$clog2(MEM_BUFFER_DEPTH_BYTES)-1:0] address;
  logic [63:0]                               data_out;
  logic                                      busy;
  logic                                      done;
  modport master (
    output start, row_words, num_rows, mem_data, mem_valid,
    input  mem_ready, wr, write_sel, address, data_out, busy, done
  );
  modport slave (
    input  start, row_words, num_rows, mem_data, mem_valid,
    output mem_ready, wr, write_sel, address, data_out, busy, done
  );
endinterface

// File: rtl/read_bank_filler.sv
// read_bank_filler: writes a stream of 64-bit beats row by row into the filter read banks.
module read_bank_filler #(
  parameter int BANK_WIDTH             = 10,
  parameter int MEM_BUFFER_DEPTH_BYTES = 512
) (
  input logic              clk,
  input logic              rst_n,
  read_bank_filler_if.slave bus
);
  localparam int WORDS = MEM_BUFFER_DEPTH_BYTES / 8;
  localparam int WW    = $clog2(WORDS);
  localparam int RWW   = WW + 1;
  localparam int SW    = $clog2(BANK_WIDTH);
  localparam int NRW   = SW + 1;
  localparam int AW    = $clog2(MEM_BUFFER_DEPTH_BYTES);
  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;
  state_t         state;
  logic [NRW-1:0] nr, nr_c;
  logic [RWW-1:0] rw, rw_c;
  logic [WW-1:0]  word_cnt;
  logic [SW-1:0]  row_cnt;
  logic           last_word, last_row;
  always_comb begin
    nr_c      = bus.num_rows > NRW'(BANK_WIDTH) ? NRW'(BANK_WIDTH) : bus.num_rows;
    rw_c      = bus.row_words > RWW'(WORDS) ? RWW'(WORDS) : bus.row_words;
    last_word = RWW'(word_cnt) == rw - RWW'(1);
    last_row  = NRW'(row_cnt) == nr - NRW'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      nr            <= '0;
      rw            <= '0;
      word_cnt      <= '0;
      row_cnt       <= '0;
      bus.wr        <= 1'b0;
      bus.write_sel <= '0;
      bus.address   <= '0;
      bus.data_out  <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.mem_ready <= 1'b0;
    end else begin
      bus.wr   <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          nr       <= nr_c;
          rw       <= rw_c;
          word_cnt <= '0;
          row_cnt  <= '0;
          if (nr_c == '0 || rw_c == '0) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            state         <= FILL;
            bus.busy      <= 1'b1;
            bus.mem_ready <= 1'b1;
          end
        end
        FILL: if (bus.mem_valid && bus.mem_ready) begin
          bus.wr        <= 1'b1;
          bus.data_out  <= bus.mem_data;
          bus.write_sel <= row_cnt;
          bus.address   <= AW'({word_cnt, 3'b000});
          word_cnt      <= last_word ? '0 : word_cnt + WW'(1);
          if (last_word && last_row) begin
            state         <= DRAIN;
            bus.mem_ready <= 1'b0;
          end else if (last_word)
            row_cnt <= row_cnt + SW'(1);
        end
        DRAIN: begin
          state    <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_read_bank_filler.sv
// tb_read_bank_filler: directed scenarios with hand-computed write sequences and done timing.
module tb_read_bank_filler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  read_bank_filler_if bus ();
  read_bank_filler dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int nvec = 0, nerr = 0, cyc = 0, ready_cnt = 0;
  int          wc[$];
  logic [3:0]  ws[$];
  logic [8:0]  wa[$];
  logic [63:0] wd[$];
  int          dc[$];
  logic        db[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.wr) begin
      wc.push_back(cyc);
      ws.push_back(bus.write_sel);
      wa.push_back(bus.address);
      wd.push_back(bus.data_out);
    end
    if (bus.done) begin
      dc.push_back(cyc);
      db.push_back(bus.busy);
    end
    if (bus.mem_ready) ready_cnt++;
  end
  task automatic clear_log();
    wc.delete(); ws.delete(); wa.delete(); wd.delete(); dc.delete(); db.delete();
    ready_cnt = 0;
  endtask
  task automatic do_start(input int r, input int w, output int t);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_rows  = 5'(r);
    bus.row_words = 7'(w);
    t = cyc;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  // Beats carry data 1..n; inj >= 0 raises start (sized 1x1) on that driving cycle.
  task automatic feed(input int n, input bit gaps, input int inj);
    int sent = 0;
    int k = 0;
    while (sent < n && k < 3000) begin
      @(negedge clk);
      bus.mem_valid = !gaps || (k % 2 == 0);
      bus.mem_data  = 64'(sent + 1);
      bus.start     = (k == inj);
      if (k == inj) begin
        bus.num_rows  = 5'd1;
        bus.row_words = 7'd1;
      end
      if (bus.mem_valid && bus.mem_ready) sent++;
      k++;
    end
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.start     = 1'b0;
    nvec++;
    if (sent !== n) begin
      nerr++;
      $display("FAIL feed_timeout accepted=%0d required=%0d", sent, n);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    nvec++; if (bus.wr !== 1'b0) begin nerr++; $display("FAIL reset_wr got=%b exp=0", bus.wr); end
    nvec++; if (bus.write_sel !== 4'd0) begin nerr++; $display("FAIL reset_sel got=%0d exp=0", bus.write_sel); end
    nvec++; if (bus.address !== 9'd0) begin nerr++; $display("FAIL reset_addr got=%0d exp=0", bus.address); end
    nvec++; if (bus.data_out !== 64'd0) begin nerr++; $display("FAIL reset_data got=%0h exp=0", bus.data_out); end
    nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    nvec++; if (bus.mem_ready !== 1'b0) begin nerr++; $display("FAIL reset_ready got=%b exp=0", bus.mem_ready); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_basic();
    int t;
    clear_log();
    do_start(2, 3, t);
    feed(6, 1'b0, -1);
    repeat (4) @(negedge clk);
    #1;
    nvec++; if (wc.size() !== 6) begin nerr++; $display("FAIL basic_count got=%0d exp=6", wc.size()); end
    nvec++; if (wc[0] !== t + 2) begin nerr++; $display("FAIL basic_latency got=%0d exp=%0d", wc[0], t + 2); end
    for (int i = 0; i < 6; i++) begin
      nvec++;
      if (ws[i] !== 4'(i / 3) || wa[i] !== 9'((i % 3) * 8) || wd[i] !== 64'(i + 1) || wc[i] !== wc[0] + i) begin
        nerr++;
        $display("FAIL basic_write%0d got=(%0d,%0d,%0d,c%0d) exp=(%0d,%0d,%0d,c%0d)", i, ws[i], wa[i], wd[i], wc[i], i / 3, (i % 3) * 8, i + 1, wc[0] + i);
      end
    end
    nvec++; if (dc.size() !== 1) begin nerr++; $display("FAIL basic_done_count got=%0d exp=1", dc.size()); end
    nvec++; if (dc[0] !== wc[5] + 1) begin nerr++; $display("FAIL basic_done_cycle got=%0d exp=%0d", dc[0], wc[5] + 1); end
    nvec++; if (db[0] !== 1'b0) begin nerr++; $display("FAIL basic_done_busy got=%b exp=0", db[0]); end
  endtask
  task automatic test_backpressure();
    int t;
    clear_log();
    do_start(2, 3, t);
    feed(6, 1'b1, -1);
    repeat (4) @(negedge clk);
    #1;
    nvec++; if (wc.size() !== 6) begin nerr++; $display("FAIL bp_count got=%0d exp=6", wc.size()); end
    for (int i = 0; i < 6; i++) begin
      nvec++;
      if (ws[i] !== 4'(i / 3) || wa[i] !== 9'((i % 3) * 8) || wd[i] !== 64'(i + 1) || wc[i] !== wc[0] + 2 * i) begin
        nerr++;
        $display("FAIL bp_write%0d got=(%0d,%0d,%0d,c%0d) exp=(%0d,%0d,%0d,c%0d)", i, ws[i], wa[i], wd[i], wc[i], i / 3, (i % 3) * 8, i + 1, wc[0] + 2 * i);
      end
    end
    nvec++; if (dc.size() !== 1 || dc[0] !== wc[5] + 1) begin nerr++; $display("FAIL bp_done got=%0d@%0d exp=1@%0d", dc.size(), dc[0], wc[5] + 1); end
  endtask
  task automatic test_clamp();
    int t;
    clear_log();
    do_start(15, 100, t);
    feed(640, 1'b0, -1);
    repeat (4) @(negedge clk);
    #1;
    nvec++; if (wc.size() !== 640) begin nerr++; $display("FAIL clamp_count got=%0d exp=640", wc.size()); end
    nvec++; if (wc[639] - wc[0] !== 639) begin nerr++; $display("FAIL clamp_span got=%0d exp=639", wc[639] - wc[0]); end
    nvec++; if (ws[639] !== 4'd9 || wa[639] !== 9'd504 || wd[639] !== 64'd640) begin nerr++; $display("FAIL clamp_last got=(%0d,%0d,%0d) exp=(9,504,640)", ws[639], wa[639], wd[639]); end
    nvec++; if (ws[63] !== 4'd0 || wa[63] !== 9'd504) begin nerr++; $display("FAIL clamp_row0_end got=(%0d,%0d) exp=(0,504)", ws[63], wa[63]); end
    nvec++; if (ws[64] !== 4'd1 || wa[64] !== 9'd0) begin nerr++; $display("FAIL clamp_row1_start got=(%0d,%0d) exp=(1,0)", ws[64], wa[64]); end
    nvec++; if (dc.size() !== 1 || dc[0] !== wc[639] + 1) begin nerr++; $display("FAIL clamp_done got=%0d@%0d exp=1@%0d", dc.size(), dc[0], wc[639] + 1); end
  endtask
  task automatic test_zero();
    int t;
    for (int z = 0; z < 2; z++) begin
      clear_log();
      if (z == 0) do_start(0, 3, t);
      else        do_start(2, 0, t);
      repeat (4) @(negedge clk);
      #1;
      nvec++; if (wc.size() !== 0) begin nerr++; $display("FAIL zero%0d_writes got=%0d exp=0", z, wc.size()); end
      nvec++; if (ready_cnt !== 0) begin nerr++; $display("FAIL zero%0d_ready got=%0d exp=0", z, ready_cnt); end
      nvec++; if (dc.size() !== 1 || dc[0] !== t + 1) begin nerr++; $display("FAIL zero%0d_done got=%0d@%0d exp=1@%0d", z, dc.size(), dc[0], t + 1); end
    end
  endtask
  task automatic test_start_busy();
    int t;
    clear_log();
    do_start(2, 3, t);
    feed(6, 1'b0, 2);
    repeat (6) @(negedge clk);
    #1;
    nvec++; if (wc.size() !== 6) begin nerr++; $display("FAIL busy_count got=%0d exp=6", wc.size()); end
    for (int i = 0; i < 6; i++) begin
      nvec++;
      if (ws[i] !== 4'(i / 3) || wa[i] !== 9'((i % 3) * 8) || wd[i] !== 64'(i + 1)) begin
        nerr++;
        $display("FAIL busy_write%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", i, ws[i], wa[i], wd[i], i / 3, (i % 3) * 8, i + 1);
      end
    end
    nvec++; if (dc.size() !== 1 || dc[0] !== wc[5] + 1) begin nerr++; $display("FAIL busy_done got=%0d@%0d exp=1@%0d", dc.size(), dc[0], wc[5] + 1); end
  endtask
  task automatic test_reset_mid();
    int t;
    clear_log();
    do_start(2, 3, t);
    feed(4, 1'b0, -1);
    #1;
    nvec++; if (wc.size() !== 4) begin nerr++; $display("FAIL rmid_prewrites got=%0d exp=4", wc.size()); end
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({bus.wr, bus.busy, bus.done, bus.mem_ready} !== 4'b0 || bus.write_sel !== 4'd0 || bus.address !== 9'd0 || bus.data_out !== 64'd0) begin
      nerr++;
      $display("FAIL rmid_outputs got=wr%b busy%b done%b rdy%b sel%0d addr%0d data%0h exp=all zero", bus.wr, bus.busy, bus.done, bus.mem_ready, bus.write_sel, bus.address, bus.data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    repeat (10) @(negedge clk);
    #1;
    nvec++; if (wc.size() !== 0 || dc.size() !== 0 || ready_cnt !== 0) begin nerr++; $display("FAIL rmid_quiet got=wr%0d done%0d rdy%0d exp=0,0,0", wc.size(), dc.size(), ready_cnt); end
    clear_log();
    do_start(1, 1, t);
    feed(1, 1'b0, -1);
    repeat (4) @(negedge clk);
    #1;
    nvec++; if (wc.size() !== 1 || ws[0] !== 4'd0 || wa[0] !== 9'd0 || wd[0] !== 64'd1) begin nerr++; $display("FAIL rmid_refill got=n%0d (%0d,%0d,%0d) exp=n1 (0,0,1)", wc.size(), ws[0], wa[0], wd[0]); end
    nvec++; if (dc.size() !== 1 || dc[0] !== wc[0] + 1) begin nerr++; $display("FAIL rmid_refill_done got=%0d@%0d exp=1@%0d", dc.size(), dc[0], wc[0] + 1); end
  endtask
  initial begin
    bus.start     = 1'b0;
    bus.num_rows  = '0;
    bus.row_words = '0;
    bus.mem_data  = '0;
    bus.mem_valid = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_clamp();
    test_zero();
    test_start_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
